acc_mul_seq: RTL and testbench

Sequencer that drives the accumulator pair and the ALU to perform an unsigned 4×4 → 8-bit shift-and-add multiply.

- The multiplier is taken from the data bus on a start request.
- The multiplicand is whatever the ALU's B operand register holds.
- The product is left in acc high:low.
- Sits between the CPU control unit (start/busy/done) and the accumulator/ALU select lines. It owns those lines while busy and holds them idle otherwise.

---
 rtl/acc_mul_seq_pkg.sv | 31 +++
 rtl/acc_mul_seq.sv | 154 +++++++++++++++
 tb/tb_acc_mul_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_mul_seq_pkg
// Description : Shared definitions for the shift-and-add multiply sequencer:
//               accumulator select codes, sequencer state encoding and the
//               default iteration count (operand width).
// Revision    : 1.0 - initial release
// ============================================================================
package acc_mul_seq_pkg;

    // Default number of multiply iterations (operand width in bits)
    localparam int c_ITER_DEFAULT = 4;

    // Accumulator half mode select codes
    localparam logic [1:0] c_SEL_HOLD = 2'b00;
    localparam logic [1:0] c_SEL_SHR  = 2'b01;
    localparam logic [1:0] c_SEL_SHL  = 2'b10;
    localparam logic [1:0] c_SEL_LOAD = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_MOVE_LO = 3'd2,
        ST_ITER    = 3'd3,
        ST_SHIFT   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage : acc_mul_seq_pkg
`default_nettype wire

// File: rtl/acc_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : acc_mul_seq
// Description : Sequencer driving the accumulator pair and ALU through an
//               unsigned ITER x ITER shift-and-add multiply. The multiplier
//               is loaded from the bus into acc high, moved into acc low,
//               then each multiplier bit (acc low bit 0) conditionally adds
//               the ALU B operand into acc high before the pair shifts right.
//               The product ends up in {acc high, acc low}.
// Ports       : clk, reset_p          - clock, synchronous active-high reset
//               start                 - operation request (sampled in IDLE)
//               acc_low_lsb           - current multiplier bit
//               alu_carry             - ALU adder carry-out (combinational)
//               acc_high_select[1:0]  - acc high mode (hold/shr/shl/load)
//               acc_low_select[1:0]   - acc low mode, same encoding
//               acc_in_select         - acc high input: 1 = bus, 0 = ALU
//               fill_value            - bit entering acc high MSB on shr
//               acc_high_reset_p      - clear acc high at next edge
//               alu_add               - request ALU acc_high + B
//               busy, done            - status to the control unit
// Revision    : 1.0 - initial release
// ============================================================================
module acc_mul_seq
    import acc_mul_seq_pkg::*;
#(
    parameter int ITER = c_ITER_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       start,
    input  logic       acc_low_lsb,
    input  logic       alu_carry,
    output logic [1:0] acc_high_select,
    output logic [1:0] acc_low_select,
    output logic       acc_in_select,
    output logic       fill_value,
    output logic       acc_high_reset_p,
    output logic       alu_add,
    output logic       busy,
    output logic       done
);

    localparam int c_CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ITER - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 r_carry;
    logic                 w_carry_next;
    logic                 w_do_shift;

    // ------------------------------------------------------------------
    // State, iteration counter and carry flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_carry <= w_carry_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_carry_next     = r_carry;
        w_do_shift       = 1'b0;
        acc_high_select  = c_SEL_HOLD;
        acc_low_select   = c_SEL_HOLD;
        acc_in_select    = 1'b0;
        fill_value       = 1'b0;
        acc_high_reset_p = 1'b0;
        alu_add          = 1'b0;
        done             = 1'b0;
        busy             = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                // Multiplier arrives on the bus this cycle
                acc_in_select   = 1'b1;
                acc_high_select = c_SEL_LOAD;
                w_state_next    = ST_MOVE_LO;
            end
            ST_MOVE_LO: begin
                // Low takes the multiplier from high while high clears
                acc_low_select   = c_SEL_LOAD;
                acc_high_reset_p = 1'b1;
                w_carry_next     = 1'b0;
                w_cnt_next       = '0;
                w_state_next     = ST_ITER;
            end
            ST_ITER: begin
                if (acc_low_lsb) begin
                    alu_add         = 1'b1;
                    acc_in_select   = 1'b0;
                    acc_high_select = c_SEL_LOAD;
                    w_carry_next    = alu_carry;
                    w_state_next    = ST_SHIFT;
                end else begin
                    // Zero multiplier bit: skip the add and shift right away
                    w_do_shift = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_do_shift = 1'b1;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_do_shift) begin
            acc_high_select = c_SEL_SHR;
            acc_low_select  = c_SEL_SHR;
            // Only a preceding add can leave a carry to shift in
            fill_value      = (r_state == ST_SHIFT) ? r_carry : 1'b0;
            w_carry_next    = 1'b0;
            w_cnt_next      = r_cnt + c_CNT_W'(1);
            w_state_next    = (r_cnt == c_CNT_LAST) ? ST_DONE : ST_ITER;
        end

        // While reset is held the accumulator must not be disturbed
        if (reset_p) begin
            acc_high_select  = c_SEL_HOLD;
            acc_low_select   = c_SEL_HOLD;
            acc_in_select    = 1'b0;
            fill_value       = 1'b0;
            acc_high_reset_p = 1'b0;
            alu_add          = 1'b0;
            done             = 1'b0;
            busy             = 1'b0;
        end
    end

endmodule : acc_mul_seq
`default_nettype wire

// File: tb/tb_acc_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_mul_seq
// Description : Self-checking bench for acc_mul_seq. Surrounds the sequencer
//               with a behavioural accumulator pair, B register and adder;
//               expected products (B * multiplier) and done timing
//               (3 + ITER + popcount) are queued at launch and checked by an
//               independent monitor when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_mul_seq;
    import acc_mul_seq_pkg::*;

    localparam int ITER = 4;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       start = 1'b0;
    logic       acc_low_lsb;
    logic       alu_carry;
    logic [1:0] acc_high_select;
    logic [1:0] acc_low_select;
    logic       acc_in_select;
    logic       fill_value;
    logic       acc_high_reset_p;
    logic       alu_add;
    logic       busy;
    logic       done;

    // Datapath environment
    logic [3:0] acc_high;
    logic [3:0] acc_low;
    logic [3:0] b_reg = 4'h0;
    logic [3:0] bus   = 4'h0;
    logic [4:0] alu_sum;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int n_add = 0;
    int n_fill = 0;
    int n_done = 0;

    typedef struct {
        int         done_cyc;
        logic [7:0] prod;
    } exp_t;
    exp_t       sb[$];
    logic       pend_prod = 1'b0;
    logic [7:0] pend_val  = 8'h00;

    acc_mul_seq #(.ITER(ITER)) dut (
        .clk              (clk),
        .reset_p          (reset_p),
        .start            (start),
        .acc_low_lsb      (acc_low_lsb),
        .alu_carry        (alu_carry),
        .acc_high_select  (acc_high_select),
        .acc_low_select   (acc_low_select),
        .acc_in_select    (acc_in_select),
        .fill_value       (fill_value),
        .acc_high_reset_p (acc_high_reset_p),
        .alu_add          (alu_add),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    assign alu_sum     = {1'b0, acc_high} + {1'b0, b_reg};
    assign alu_carry   = alu_sum[4];
    assign acc_low_lsb = acc_low[0];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_p) begin
            acc_high <= 4'h0;
            acc_low  <= 4'h0;
        end else begin
            if (acc_high_reset_p) acc_high <= 4'h0;
            else begin
                case (acc_high_select)
                    2'b01:   acc_high <= {fill_value, acc_high[3:1]};
                    2'b10:   acc_high <= {acc_high[2:0], 1'b0};
                    2'b11:   acc_high <= acc_in_select ? bus : alu_sum[3:0];
                    default: ;
                endcase
            end
            case (acc_low_select)
                2'b01:   acc_low <= {acc_high[0], acc_low[3:1]};
                2'b10:   acc_low <= {acc_low[2:0], 1'b0};
                2'b11:   acc_low <= acc_high;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations on done, checks product the cycle after
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (alu_add)    n_add++;
            if (fill_value) n_fill++;
            if (done)       n_done++;
            if (pend_prod) begin
                check("product", {24'h0, acc_high, acc_low}, {24'h0, pend_val});
                pend_prod = 1'b0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    pend_prod = 1'b1;
                    pend_val  = e.prod;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_sels"}, {26'h0, acc_high_select, acc_low_select, acc_in_select,
                               fill_value}, 32'h0);
        check({tag, "_ctl"}, {30'h0, acc_high_reset_p, alu_add}, 32'h0);
    endtask

    task automatic launch(input logic [3:0] b, input logic [3:0] m);
        exp_t e;
        @(negedge clk);
        b_reg = b;
        bus   = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.done_cyc = cyc + 2 + ITER + $countones(m);
        e.prod     = 8'(b) * 8'(m);
        sb.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !pend_prod) break;
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0 || pend_prod) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done within 40 cycles expected completion (cycle %0d)", cyc);
            sb.delete();
            pend_prod = 1'b0;
        end
    endtask

    task automatic run_op(input logic [3:0] b, input logic [3:0] m);
        launch(b, m);
        check("busy_running", {31'h0, busy}, 32'h1);
        wait_done();
        check_idle_outputs("after_op");
    endtask

    initial begin
        int a0, f0, d0;
        logic [3:0] rb, rm;

        // Reset state
        reset_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        reset_p = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Directed products
        f0 = n_fill;
        run_op(4'hF, 4'hF);
        check("fill_seen_ff", {31'h0, (n_fill != f0)}, 32'h1);
        run_op(4'h5, 4'h3);
        a0 = n_add;
        run_op(4'h7, 4'h0);
        check("no_add_m0", n_add - a0, 0);
        f0 = n_fill;
        run_op(4'h2, 4'h8);
        check("no_fill_2x8", n_fill - f0, 0);

        // Start pulsed mid-run is ignored
        d0 = n_done;
        launch(4'h3, 4'h5);
        repeat (3) @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        check("one_done", n_done - d0, 1);
        check_idle_outputs("after_noise");

        // Reset mid-operation aborts
        d0 = n_done;
        launch(4'hB, 4'h7);
        repeat (4) @(negedge clk);
        reset_p = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        sb.delete();
        check_idle_outputs("after_abort");
        repeat (12) @(negedge clk);
        check("no_done_abort", n_done - d0, 0);
        run_op(4'hB, 4'h7);

        // Randomized products
        for (int k = 0; k < 20; k++) begin
            rb = 4'($urandom_range(0, 15));
            rm = 4'($urandom_range(0, 15));
            run_op(rb, rm);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_acc_mul_seq
`default_nettype wire
